// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one outstanding req/ready bus transaction at a time,
// byte-lane steering for stores, and shift/extend for loads.
module load_store_unit #(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [size-1:0] Addr_in,
  input  logic [size-1:0] Store_data,
  output logic [size-1:0] Load_data,
  output logic            load_valid,
  output logic            stall,
  output logic            fault,
  output logic            bus_req,
  output logic            bus_we,
  output logic [size-1:0] bus_addr,
  output logic [3:0]      bus_be,
  output logic [size-1:0] bus_wdata,
  input  logic            bus_ready,
  input  logic [size-1:0] bus_rdata
);

  if (size != 32) begin : g_size_check
    $error("load_store_unit: size must be 32");
  end

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  state_e          state_q;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [size-1:0] load_q, addr_q, wdata_q;
  logic [3:0]      be_q;
  logic            req_q, lvld_q;

  logic            req, illegal, misalign, bad;
  logic [3:0]      be_d;
  logic [size-1:0] wdata_d, rshift, ld_d;

  assign req = mem_write | mem_read;

  always_comb begin
    illegal = 1'b0;
    if (mem_write) illegal = !(funct3 inside {3'b000, 3'b001, 3'b010});
    else           illegal = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  end

  // funct3[1:0] encodes the access width for both loads and stores
  assign misalign = ((funct3[1:0] == 2'b01) && Addr_in[0]) ||
                    ((funct3[1:0] == 2'b10) && (Addr_in[1:0] != 2'b00));
  assign bad   = illegal | misalign;
  assign fault = (state_q == IDLE) && req && bad;
  assign stall = ((state_q == IDLE) && req && !bad) || (state_q == REQ);

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = Store_data;
    if (mem_write) begin
      case (funct3[1:0])
        2'b00: begin
          be_d    = 4'b0001 << Addr_in[1:0];
          wdata_d = {4{Store_data[7:0]}};
        end
        2'b01: begin
          be_d    = 4'b0011 << Addr_in[1:0];
          wdata_d = {2{Store_data[15:0]}};
        end
        default: begin
          be_d    = 4'b1111;
          wdata_d = Store_data;
        end
      endcase
    end
  end

  assign rshift = bus_rdata >> {off_q, 3'b000};

  always_comb begin
    case (f3_q)
      3'b000:  ld_d = {{24{rshift[7]}}, rshift[7:0]};
      3'b001:  ld_d = {{16{rshift[15]}}, rshift[15:0]};
      3'b100:  ld_d = {24'b0, rshift[7:0]};
      3'b101:  ld_d = {16'b0, rshift[15:0]};
      default: ld_d = rshift;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b0;
      off_q   <= 2'b0;
      load_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= 4'b0;
      req_q   <= 1'b0;
      lvld_q  <= 1'b0;
    end else begin
      lvld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req && !bad) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            we_q    <= mem_write;
            f3_q    <= funct3;
            off_q   <= Addr_in[1:0];
            addr_q  <= {Addr_in[size-1:2], 2'b00};
            be_q    <= be_d;
            wdata_q <= wdata_d;
          end
        end
        REQ: begin
          if (bus_ready) begin
            req_q   <= 1'b0;
            state_q <= DONE;
            if (!we_q) begin
              load_q <= ld_d;
              lvld_q <= 1'b1;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Load_data  = load_q;
  assign load_valid = lvld_q;
  assign bus_req    = req_q;
  assign bus_we     = we_q;
  assign bus_addr   = addr_q;
  assign bus_be     = be_q;
  assign bus_wdata  = wdata_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage block directly downstream of the datapath.
- Consumes the datapath's FU result (effective address) and B-register data (store data).
- Runs a single-outstanding req/ready transaction on the data-memory bus, stalling the pipeline while it waits.
- Returns aligned, sign- or zero-extended load data to the datapath's Data_in.

Parameters:
- size, 32, data/address width. Must be 32 (RV32I, 4 byte lanes); any other value is an elaboration error.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- mem_read  input  1  load request for the instruction currently in the MEM stage.
- mem_write  input  1  store request; has priority over mem_read if both are high.
- funct3  input  3  RV32I width/sign code.
- Addr_in  input  size  effective address from the datapath.
- Store_data  input  size  store operand from the datapath.
- Load_data  output  size  extended load result to the datapath; registered.
- load_valid  output  1  one-cycle pulse when Load_data is updated.
- stall  output  1  holds the pipeline (combinational).
- fault  output  1  misaligned access or illegal funct3 (combinational).
- bus_req  output  1  bus request; registered.
- bus_we  output  1  1 = write.
- bus_addr  output  size  word-aligned address, {Addr[31:2],2'b00}.
- bus_be  output  4  byte enables.
- bus_wdata  output  size  lane-replicated store data.
- bus_ready  input  1  bus completes the transfer in this cycle.
- bus_rdata  input  size  read word, valid when bus_ready=1.

Behaviour:
- Reset (reset=0, asynchronous)
  - State goes to IDLE.
  - Load_data, bus_addr and bus_wdata go to 0. bus_req, bus_we, bus_be and load_valid go to 0.
  - Reset mid-transaction drops bus_req immediately and discards the pending access.
- funct3 decoding
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Every other code is illegal for the active request type.
- Alignment
  - Halfword needs Addr_in[0]=0. Word needs Addr_in[1:0]=0.
- Request
  - req = mem_write | mem_read. The type is store if mem_write=1, else load.
- State IDLE
  - Faulty request (illegal funct3 or misaligned):
    - fault=1 and stall=0 in the same cycle.
    - No bus transaction; state stays IDLE; Load_data is unchanged.
  - Legal request:
    - stall=1.
    - On the clock edge: latch the type, funct3 and Addr_in[1:0]. Drive bus_addr, bus_we, bus_be and bus_wdata; set bus_req=1; go to REQ.
- State REQ
  - stall=1, fault=0.
  - bus_req, bus_we, bus_addr, bus_be and bus_wdata are held stable until a cycle with bus_ready=1.
  - On a bus_ready=1 edge: bus_req goes to 0 and the state goes to DONE.
  - For a load, Load_data is written with the extended result and load_valid=1 on the next cycle.
  - Request inputs are ignored while in REQ.
- State DONE
  - stall=0 and load_valid is as set above. The instruction retires at the end of this cycle.
  - Request inputs still belong to the completed instruction and are ignored.
  - Next state is always IDLE.
- Minimum latency is 3 cycles (IDLE, REQ with bus_ready=1, DONE). Each extra wait cycle in REQ adds 1.
- Store lanes (o = Addr[1:0])
  - SB: bus_wdata = {4{d[7:0]}}, bus_be = 4'b0001<<o.
  - SH: bus_wdata = {2{d[15:0]}}, bus_be = 4'b0011<<o.
  - SW: bus_wdata = d, bus_be = 4'b1111.
- Loads
  - bus_be = 4'b1111.
  - Shift: r = bus_rdata >> (8*o).
  - LB sign-extends r[7:0]. LBU zero-extends r[7:0].
  - LH sign-extends r[15:0]. LHU zero-extends r[15:0].
  - LW returns r.
- Load_data holds its value across stores, faults and idle cycles.
- bus_ready outside REQ is ignored.

Test Plan:
1. LW, Addr_in=0x100, bus_ready=1 on the first REQ cycle, bus_rdata=0xDEADBEEF:
   - bus_addr=0x100, bus_be=1111, stall=1 for 2 cycles.
   - Then Load_data=0xDEADBEEF and load_valid=1 for 1 cycle.
2. LB at 0x203 with rdata=0x80FF1234 -> Load_data=0xFFFFFF80. LBU at the same address -> 0x00000080.
3. SH at 0x402, Store_data=0x1234ABCD:
   - bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD.
   - With 3 wait cycles, stall stays 1 for 5 cycles total.
   - Load_data is unchanged.
4. LW at 0x101 or LH at 0x0FF, and separately funct3=011:
   - fault=1, stall=0, bus_req never rises.
5. Reset in REQ with bus_req=1: bus_req=0 and state IDLE immediately. A subsequent LW completes normally.
6. mem_read=mem_write=1, funct3=010, Addr_in=0x8: store performed with bus_we=1 and bus_be=1111.
